// File: rtl/ball_pkg.sv
// Shared constants, coordinate type and debounce states for the ball position path.
package ball_pkg;

  localparam int H_ACTIVE_DEF  = 640;
  localparam int V_ACTIVE_DEF  = 480;
  localparam int BALL_SIZE_DEF = 16;

  localparam int X_MAX = H_ACTIVE_DEF - BALL_SIZE_DEF;
  localparam int Y_MAX = V_ACTIVE_DEF - BALL_SIZE_DEF;

  typedef logic [9:0] coord_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    PRESSED   = 2'd2,
    REL_CHK   = 2'd3
  } deb_state_t;

  function automatic coord_t clamp_coord(input coord_t v, input coord_t lim);
    return (v > lim) ? lim : v;
  endfunction

  // Move cur toward tgt by at most step; the distance is taken at 11 bits so it cannot wrap.
  function automatic coord_t step_toward(input coord_t cur, input coord_t tgt, input coord_t step);
    logic signed [10:0] d;
    coord_t             mag;
    coord_t             res;
    d   = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    res = cur;
    mag = '0;
    if (d > 11'sd0) begin
      mag = d[9:0];
      res = cur + ((mag < step) ? mag : step);
    end else if (d < 11'sd0) begin
      mag = coord_t'(-d);
      res = cur - ((mag < step) ? mag : step);
    end
    return res;
  endfunction

endpackage

// File: rtl/ball_pos_ctrl_btn_debounce.sv
// Two-flop synchroniser plus press/release debounce; one pulse per accepted press.
// Pulse appears 2+DEB_CYCLES cycles after a clean rise; no backpressure.
module btn_debounce
  import ball_pkg::*;
#(
  parameter int DEB_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          sync1;
  logic          btn_s;
  deb_state_t    state;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      btn_s <= 1'b0;
      state <= IDLE;
      cnt   <= '0;
    end else begin
      sync1 <= btn;
      btn_s <= sync1;
      case (state)
        IDLE: begin
          if (btn_s) begin
            state <= PRESS_CHK;
            cnt   <= '0;
          end
        end
        PRESS_CHK: begin
          if (!btn_s)               state <= IDLE;
          else if (cnt == CNT_LAST) state <= PRESSED;
          else                      cnt   <= cnt + CNT_ONE;
        end
        PRESSED: begin
          if (!btn_s) begin
            state <= REL_CHK;
            cnt   <= '0;
          end
        end
        REL_CHK: begin
          if (btn_s)                state <= PRESSED;
          else if (cnt == CNT_LAST) state <= IDLE;
          else                      cnt   <= cnt + CNT_ONE;
        end
      endcase
    end
  end

  // Decoded from registered state only, so it is high for exactly the cycle before PRESSED.
  assign pulse = (state == PRESS_CHK) && btn_s && (cnt == CNT_LAST);

endmodule

// File: rtl/ball_pos_ctrl.sv
// Debounced target capture and once-per-frame ball stepping for the VGA ball renderer; no backpressure.
// BALL_POS_INSTANT_EN: ball jumps straight to the target on frame_start instead of stepping.
module ball_pos_ctrl
  import ball_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int BALL_SIZE  = BALL_SIZE_DEF,
  parameter int STEP       = 4,
  parameter int DEB_CYCLES = 250000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] sw,
  input  logic       choose_xy,
  input  logic       load_btn,
  input  logic       frame_start,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [9:0] target_x,
  output logic [9:0] target_y,
  output logic       moving
);

  localparam coord_t X_LIM  = coord_t'(H_ACTIVE - BALL_SIZE);
  localparam coord_t Y_LIM  = coord_t'(V_ACTIVE - BALL_SIZE);
  localparam coord_t STEP_C = coord_t'(STEP);

  logic   load_pulse;
  coord_t tx_n;
  coord_t ty_n;
  coord_t bx_n;
  coord_t by_n;

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_deb (
    .clk  (clk),
    .reset(reset),
    .btn  (load_btn),
    .pulse(load_pulse)
  );

  always_comb begin
    tx_n = target_x;
    ty_n = target_y;
    if (load_pulse) begin
      if (choose_xy) tx_n = clamp_coord(sw, X_LIM);
      else           ty_n = clamp_coord(sw, Y_LIM);
    end
  end

  // Motion reads the registered targets, so a capture on a frame edge only takes effect next frame.
  always_comb begin
    bx_n = ball_x;
    by_n = ball_y;
    if (frame_start) begin
`ifdef BALL_POS_INSTANT_EN
      bx_n = target_x;
      by_n = target_y;
`else
      bx_n = step_toward(ball_x, target_x, STEP_C);
      by_n = step_toward(ball_y, target_y, STEP_C);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ball_x   <= '0;
      ball_y   <= '0;
      target_x <= '0;
      target_y <= '0;
      moving   <= 1'b0;
    end else begin
      ball_x   <= bx_n;
      ball_y   <= by_n;
      target_x <= tx_n;
      target_y <= ty_n;
      moving   <= (bx_n != tx_n) || (by_n != ty_n);
    end
  end

endmodule

// File: tb/tb_ball_pos_ctrl.sv
// Scoreboard bench for ball_pos_ctrl with DEB_CYCLES=4, STEP=4.
module tb_ball_pos_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] sw = '0;
  logic       choose_xy = 1'b0;
  logic       load_btn = 1'b0;
  logic       frame_start = 1'b0;
  logic [9:0] ball_x, ball_y, target_x, target_y;
  logic       moving;

  ball_pos_ctrl #(
    .STEP      (4),
    .DEB_CYCLES(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sw         (sw),
    .choose_xy  (choose_xy),
    .load_btn   (load_btn),
    .frame_start(frame_start),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .target_x   (target_x),
    .target_y   (target_y),
    .moving     (moving)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [9:0] bx;
    logic [9:0] by;
    logic [9:0] tx;
    logic [9:0] ty;
    logic       mv;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  logic fs_q = 1'b0, rst_q = 1'b0, en_q = 1'b0, mon_en = 1'b0;
  logic [9:0] pbx, pby, ptx, pty;
  logic       pmv;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    fs_q  <= frame_start;
    rst_q <= reset;
    en_q  <= mon_en;
  end

  // An output is "presented" on any frame or reset edge, or whenever any output changes.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (en_q && (fs_q || rst_q || ball_x !== pbx || ball_y !== pby ||
                 target_x !== ptx || target_y !== pty || moving !== pmv)) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output: cyc=%0d got x=%0d y=%0d tx=%0d ty=%0d mv=%0b, required no change",
                 cyc, ball_x, ball_y, target_x, target_y, moving);
      end else begin
        e = q.pop_front();
        if (cyc != e.cyc || ball_x !== e.bx || ball_y !== e.by || target_x !== e.tx ||
            target_y !== e.ty || moving !== e.mv) begin
          bad++;
          $display("FAIL %s: got cyc=%0d x=%0d y=%0d tx=%0d ty=%0d mv=%0b, required cyc=%0d x=%0d y=%0d tx=%0d ty=%0d mv=%0b",
                   e.nm, cyc, ball_x, ball_y, target_x, target_y, moving,
                   e.cyc, e.bx, e.by, e.tx, e.ty, e.mv);
        end
      end
    end
    pbx = ball_x;
    pby = ball_y;
    ptx = target_x;
    pty = target_y;
    pmv = moving;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int c, input logic [9:0] bx, input logic [9:0] by,
                           input logic [9:0] tx, input logic [9:0] ty, input logic mv,
                           input string nm);
    exp_t e;
    e.cyc = c;
    e.bx  = bx;
    e.by  = by;
    e.tx  = tx;
    e.ty  = ty;
    e.mv  = mv;
    e.nm  = nm;
    q.push_back(e);
  endtask

  task automatic frame(input logic [9:0] bx, input logic [9:0] by, input logic [9:0] tx,
                       input logic [9:0] ty, input logic mv, input string nm);
    frame_start = 1'b1;
    expect_at(cyc + 1, bx, by, tx, ty, mv, nm);
    tick();
    frame_start = 1'b0;
    tick();
  endtask

  // Clean press: rise seen 2+4 cycles later as the load pulse, target visible one edge after.
  task automatic press(input logic [9:0] s, input logic c, input logic [9:0] bx,
                       input logic [9:0] by, input logic [9:0] tx, input logic [9:0] ty,
                       input logic mv, input string nm);
    sw        = s;
    choose_xy = c;
    load_btn  = 1'b1;
    expect_at(cyc + 7, bx, by, tx, ty, mv, nm);
    repeat (10) tick();
    load_btn = 1'b0;
    repeat (10) tick();
  endtask

  initial begin
    logic [7:0] pat;
    exp_t       e;

    reset = 1'b1;
    tick();
    tick();
    mon_en = 1'b1;
    expect_at(cyc + 1, 0, 0, 0, 0, 1'b0, "reset_state");
    tick();
    reset = 1'b0;
    tick();

    for (int k = 0; k < 10; k++) frame(0, 0, 0, 0, 1'b0, "idle_frame");

    press(10'd100, 1'b1, 0, 0, 100, 0, 1'b1, "load_x100");

`ifdef BALL_POS_INSTANT_EN
    frame(100, 0, 100, 0, 1'b0, "instant_x");
    frame(100, 0, 100, 0, 1'b0, "instant_hold");
    press(10'd1000, 1'b0, 100, 0, 100, 464, 1'b1, "load_y_clamp");
    frame(100, 464, 100, 464, 1'b0, "instant_y");
`else
    for (int k = 1; k <= 25; k++) frame(10'(4 * k), 0, 100, 0, (k < 25), "step_x");
    frame(100, 0, 100, 0, 1'b0, "x_settled");

    press(10'd1000, 1'b0, 100, 0, 100, 464, 1'b1, "load_y_clamp");
    for (int k = 1; k <= 116; k++) frame(100, 10'(4 * k), 100, 464, (k < 116), "step_y");
    frame(100, 464, 100, 464, 1'b0, "y_no_further");

    sw        = 10'd50;
    choose_xy = 1'b1;
    pat       = 8'b0011_0011;
    for (int i = 0; i < 8; i++) begin
      load_btn = pat[i];
      tick();
    end
    load_btn = 1'b1;
    expect_at(cyc + 7, 100, 464, 50, 464, 1'b1, "bounce_one_pulse");
    repeat (10) tick();
    load_btn = 1'b0;
    repeat (10) tick();

    sw       = 10'd300;
    load_btn = 1'b1;
    repeat (3) tick();
    load_btn = 1'b0;
    repeat (10) tick();

    for (int k = 1; k <= 12; k++) frame(10'(100 - 4 * k), 464, 50, 464, 1'b1, "step_back");
    frame(50, 464, 50, 464, 1'b0, "partial_step");
    frame(50, 464, 50, 464, 1'b0, "hold_at_target");

    press(10'd10, 1'b1, 50, 464, 10, 464, 1'b1, "load_x10");
    for (int k = 1; k <= 10; k++) frame(10'(50 - 4 * k), 464, 10, 464, (k < 10), "step_to10");

    sw        = 10'd8;
    choose_xy = 1'b1;
    load_btn  = 1'b1;
    expect_at(cyc + 7, 10, 464, 8, 464, 1'b1, "same_edge_old_target");
    repeat (6) tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    repeat (3) tick();
    load_btn = 1'b0;
    repeat (10) tick();
    frame(8, 464, 8, 464, 1'b0, "partial_step_2");

    press(10'd100, 1'b1, 8, 464, 100, 464, 1'b1, "load_x100_again");
    for (int k = 1; k <= 8; k++) frame(10'(8 + 4 * k), 464, 100, 464, 1'b1, "step_to40");

    load_btn = 1'b1;
    repeat (4) tick();
    reset = 1'b1;
    expect_at(cyc + 1, 0, 0, 0, 0, 1'b0, "reset_mid_motion");
    tick();
    reset    = 1'b0;
    load_btn = 1'b0;
    repeat (10) tick();
    for (int k = 0; k < 3; k++) frame(0, 0, 0, 0, 1'b0, "post_reset");
`endif

    repeat (3) tick();
    while (q.size() != 0) begin
      e = q.pop_front();
      total++;
      bad++;
      $display("FAIL %s: got no output event, required one at cyc=%0d", e.nm, e.cyc);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
